// File: rtl/addr8u_sched_pkg.sv
// Shared widths, FSM state type and fault-counter helpers for the round-robin
// time-redundant adder scheduler.
package addr8u_sched_pkg;

   localparam int OP_W   = 8;
   localparam int SUM_W  = 9;
   localparam int FCNT_W = 8;
   localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      P1   = 2'd1,
      P2   = 2'd2,
      RESP = 2'd3
   } state_t;

   function automatic logic [FCNT_W-1:0] fcnt_inc(input logic [FCNT_W-1:0] cnt);
      return (cnt == FCNT_MAX) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/addr8u_rr_sched_if.sv
// Request/response bundle between the requesting engines (master) and the
// scheduler (slave).
interface addr8u_rr_sched_if
   import addr8u_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*OP_W-1:0] req_a;
   logic [NUM_REQ*OP_W-1:0] req_b;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [SUM_W-1:0]        resp_sum;
   logic [ID_W-1:0]         resp_id;
   logic                    resp_err;
   logic [FCNT_W-1:0]       fault_cnt;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_sum, resp_id, resp_err, fault_cnt
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_sum, resp_id, resp_err, fault_cnt
   );

endinterface

// File: rtl/addr8u_core.sv
// Shared combinational adder datapath, 8+8 -> 9 bits with carry-out.
// Any adder variant with the same pins can drop in here.
module addr8u_core
   import addr8u_sched_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [SUM_W-1:0] sum
);

   assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/addr8u_rr_sched.sv
// Round-robin scheduler sharing one adder core, with A+B / B+A time redundancy.
// Define ADDR8U_RETRY_EN to re-run mismatching requests up to MAX_RETRY times.
//
// state | meaning
// IDLE  | waiting for a request; grants first valid index at/after ptr
// P1    | core computes a+b, result captured into r1
// P2    | core computes b+a, compared against r1 on exit
// RESP  | result held on resp_* until resp_ready
module addr8u_rr_sched
   import addr8u_sched_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_RETRY = 2
)(
   input  logic               clk,
   input  logic               rst,
   addr8u_rr_sched_if.slave   bus
);

   localparam int ID_W = $clog2(NUM_REQ);
`ifdef ADDR8U_RETRY_EN
   localparam int RETRIES = MAX_RETRY;
`else
   localparam int RETRIES = 0;
`endif

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cur_id;
   logic [ID_W-1:0]   gnt_id;
   logic              gnt_any;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic [OP_W-1:0]   core_a;
   logic [OP_W-1:0]   core_b;
   logic [SUM_W-1:0]  core_sum;
   logic [SUM_W-1:0]  r1;
   logic [2:0]        retry_cnt;
   logic              resp_valid_q;
   logic [SUM_W-1:0]  resp_sum_q;
   logic [ID_W-1:0]   resp_id_q;
   logic              resp_err_q;
   logic [FCNT_W-1:0] fault_cnt_q;

   // Scan downwards so the smallest offset from ptr wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (bus.req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      bus.req_ready = '0;
      if (state == IDLE && gnt_any && !rst)
         bus.req_ready[gnt_id] = 1'b1;
   end

   always_comb begin
      core_a = '0;
      core_b = '0;
      case (state)
         P1: begin
            core_a = op_a;
            core_b = op_b;
         end
         P2: begin
            core_a = op_b;
            core_b = op_a;
         end
         default: ;
      endcase
   end

   addr8u_core u_core (
      .a   (core_a),
      .b   (core_b),
      .sum (core_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         cur_id       <= '0;
         op_a         <= '0;
         op_b         <= '0;
         r1           <= '0;
         retry_cnt    <= '0;
         resp_valid_q <= 1'b0;
         resp_sum_q   <= '0;
         resp_id_q    <= '0;
         resp_err_q   <= 1'b0;
         fault_cnt_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  op_a      <= bus.req_a[gnt_id*OP_W +: OP_W];
                  op_b      <= bus.req_b[gnt_id*OP_W +: OP_W];
                  cur_id    <= gnt_id;
                  ptr       <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                  retry_cnt <= '0;
                  state     <= P1;
               end
            end
            P1: begin
               r1    <= core_sum;
               state <= P2;
            end
            P2: begin
               // The second pass is compared live, so it needs no register of its own.
               if (core_sum == r1) begin
                  resp_sum_q   <= r1;
                  resp_err_q   <= 1'b0;
                  resp_id_q    <= cur_id;
                  resp_valid_q <= 1'b1;
                  state        <= RESP;
               end else begin
                  fault_cnt_q <= fcnt_inc(fault_cnt_q);
                  if (int'(retry_cnt) < RETRIES) begin
                     retry_cnt <= retry_cnt + 1'b1;
                     state     <= P1;
                  end else begin
                     resp_sum_q   <= r1;
                     resp_err_q   <= 1'b1;
                     resp_id_q    <= cur_id;
                     resp_valid_q <= 1'b1;
                     state        <= RESP;
                  end
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_sum   = resp_sum_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_addr8u_rr_sched.sv
// Bench for addr8u_rr_sched: transaction-level model (RR order, latency, sum,
// fault accounting) checked every cycle, plus literal expectations per scenario.
module tb_addr8u_rr_sched;
   import addr8u_sched_pkg::*;

   localparam int N  = 4;
   localparam int MR = 2;
`ifdef ADDR8U_RETRY_EN
   localparam bit RETRY_BUILD = 1'b1;
`else
   localparam bit RETRY_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   addr8u_rr_sched_if #(.NUM_REQ(N)) bus ();

   addr8u_rr_sched #(.NUM_REQ(N), .MAX_RETRY(MR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- model state ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         busy = 1'b0;
   bit         seen_v = 1'b0;
   bit         inj_on = 1'b0;
   int         ptr_m = 0;
   int         fcnt_m = 0;
   int         fcnt_r = 0;
   int         gcyc = 0, vcyc = 0, lat = 0;
   int         gsel, retries, ninj;
   int         inj_k = 0;
   int         inj_left = 0, inj_next = 0;
   int         e_id = 0;
   logic [8:0] e_sum = '0;
   bit         e_err = 1'b0;
   int         gq[$];
   int         gcq[$];
   logic [8:0] last_sum = '0;
   int         last_id = 0, last_lat = 0;
   bit         last_err = 1'b0;
   logic [N-1:0] er;

   // Injection forces the pass-2 core output to 0x31: bit0 stuck-at-1 on 0x10+0x20.
   always @(negedge clk) begin
      if (rst) begin
         busy     = 1'b0;
         ptr_m    = 0;
         fcnt_m   = 0;
         inj_left = 0;
         if (inj_on) begin
            release dut.core_sum;
            inj_on = 1'b0;
         end
      end else begin
         if (!busy) begin
            gsel = -1;
            for (int k = 0; k < N; k++)
               if (gsel < 0 && bus.req_valid[(ptr_m + k) % N]) gsel = (ptr_m + k) % N;
            er = '0;
            if (gsel >= 0) er[gsel] = 1'b1;
            chk("grant_onehot", bus.req_ready, er);
            chk("idle_resp_valid", bus.resp_valid, 0);
            chk("idle_fault_cnt", bus.fault_cnt, fcnt_m);
            if (gsel >= 0) begin
               busy    = 1'b1;
               seen_v  = 1'b0;
               gcyc    = cyc;
               e_id    = gsel;
               e_sum   = 9'(bus.req_a[gsel*8 +: 8]) + 9'(bus.req_b[gsel*8 +: 8]);
               retries = RETRY_BUILD ? ((inj_k < MR) ? inj_k : MR) : 0;
               ninj    = (inj_k < retries + 1) ? inj_k : retries + 1;
               e_err   = (inj_k > retries);
               lat     = 3 + 2 * retries;
               fcnt_r  = (fcnt_m + ninj > 255) ? 255 : fcnt_m + ninj;
               inj_left = ninj;
               inj_next = cyc + 2;
               ptr_m   = (gsel + 1) % N;
               gq.push_back(gsel);
               gcq.push_back(cyc);
            end
         end else begin
            chk("busy_req_ready", bus.req_ready, 0);
            chk("resp_valid_timing", bus.resp_valid, (cyc >= gcyc + lat) ? 1 : 0);
            if (bus.resp_valid) begin
               if (!seen_v) begin
                  seen_v = 1'b1;
                  vcyc   = cyc;
               end
               chk("resp_sum", bus.resp_sum, e_sum);
               chk("resp_id", bus.resp_id, e_id);
               chk("resp_err", bus.resp_err, e_err);
               chk("resp_fault_cnt", bus.fault_cnt, fcnt_r);
               if (bus.resp_ready) begin
                  busy     = 1'b0;
                  fcnt_m   = fcnt_r;
                  last_sum = bus.resp_sum;
                  last_id  = bus.resp_id;
                  last_err = bus.resp_err;
                  last_lat = vcyc - gcyc;
               end
            end
         end
         if (inj_on) begin
            release dut.core_sum;
            inj_on = 1'b0;
         end
         if (busy && inj_left > 0 && cyc == inj_next) begin
            force dut.core_sum = 9'h031;
            inj_on   = 1'b1;
            inj_left = inj_left - 1;
            inj_next = inj_next + 2;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      logic [N-1:0] r;
      @(negedge clk);
      r = bus.req_ready;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~r;
   endtask

   task automatic post(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[i*8 +: 8] = a;
      bus.req_b[i*8 +: 8] = b;
      bus.req_valid[i]    = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      tick();
      while ((busy || bus.req_valid != '0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) chk("wait_idle_timeout", 1, 0);
   endtask

   initial begin
      int base;
      bit re;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk("por_resp_valid", bus.resp_valid, 0);
      chk("por_fault_cnt", bus.fault_cnt, 0);
      chk("por_resp_sum", bus.resp_sum, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1. reset mid-P2 with req0 pending
      post(0, 8'h05, 8'h07);
      tick();
      tick();
      post(0, 8'h05, 8'h07);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_resp_valid", bus.resp_valid, 0);
      chk("rst_resp_sum", bus.resp_sum, 0);
      chk("rst_resp_id", bus.resp_id, 0);
      chk("rst_resp_err", bus.resp_err, 0);
      chk("rst_fault_cnt", bus.fault_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_idle(30);
      chk("rst_then_req0_sum", last_sum, 9'h00C);
      chk("rst_then_req0_id", last_id, 0);

      // 2. single request with carry out
      post(1, 8'hFF, 8'h01);
      wait_idle(30);
      chk("single_sum", last_sum, 9'h100);
      chk("single_id", last_id, 1);
      chk("single_err", last_err, 0);
      chk("single_latency", last_lat, 3);

      post(2, 8'hFF, 8'hFF);
      wait_idle(30);
      chk("max_sum", last_sum, 9'h1FE);

      // 3. fairness from ptr=0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      base = gq.size();
      for (int i = 0; i < N; i++) post(i, 8'(8'h11 * (i + 1)), 8'(i + 3));
      re = 1'b0;
      for (int n = 0; n < 60 && !(gq.size() - base >= 5 && !busy); n++) begin
         tick();
         if (!re && gq.size() - base >= 1) begin
            post(0, 8'h40, 8'h02);
            re = 1'b1;
         end
      end
      chk("fair_count", gq.size() - base, 5);
      if (gq.size() - base >= 5) begin
         chk("fair_g0", gq[base], 0);
         chk("fair_g1", gq[base+1], 1);
         chk("fair_g2", gq[base+2], 2);
         chk("fair_g3", gq[base+3], 3);
         chk("fair_g4", gq[base+4], 0);
         for (int i = 0; i < 4; i++)
            chk("fair_spacing", gcq[base+i+1] - gcq[base+i], 4);
      end
      chk("fair_last_sum", last_sum, 9'h042);

      // 4. backpressure
      bus.resp_ready = 1'b0;
      base = gq.size();
      post(2, 8'h33, 8'h44);
      post(3, 8'h01, 8'h02);
      repeat (14) tick();
      chk("bp_valid_held", bus.resp_valid, 1);
      chk("bp_sum_held", bus.resp_sum, 9'h077);
      chk("bp_id_held", bus.resp_id, 2);
      chk("bp_one_grant", gq.size() - base, 1);
      bus.resp_ready = 1'b1;
      wait_idle(40);
      chk("bp_next_grant", gq[$], 3);
      chk("bp_next_sum", last_sum, 9'h003);

      // 5. stuck-at-1 on bit0 during every pass 2
      inj_k = 8;
      post(0, 8'h10, 8'h20);
      wait_idle(40);
      inj_k = 0;
      chk("stuck_sum", last_sum, 9'h030);
      chk("stuck_err", last_err, 1);
      chk("stuck_fault_cnt", bus.fault_cnt, RETRY_BUILD ? 3 : 1);
      chk("stuck_latency", last_lat, RETRY_BUILD ? 7 : 3);

      // 6. single transient on the first pass 2
      inj_k = 1;
      post(1, 8'h10, 8'h20);
      wait_idle(40);
      inj_k = 0;
      chk("trans_sum", last_sum, 9'h030);
      chk("trans_err", last_err, RETRY_BUILD ? 0 : 1);
      chk("trans_fault_cnt", bus.fault_cnt, RETRY_BUILD ? 4 : 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
